// File: rtl/lzc_normalizer_pipe.sv
// ---------------------------------------------------------------------------
// lzc_normalizer_pipe
//
// Two-stage pipelined leading-zero / leading-one counter with mantissa
// normaliser, used for floating-point post-normalisation.
//
// Stage 1 counts the leading zeros of in_data (mode 0) or of ~in_data
// (mode 1). It registers the payload together with that count.
// Stage 2 left-shifts the mantissa by the count and lowers the exponent by
// the same amount. The shift is limited so the exponent never goes below 0.
// When that limit is hit, the underflow flag is raised.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_data    in   WIDTH  mantissa to normalise
//   in_exp     in   EXP_W  exponent of in_data (unsigned)
//   in_mode    in   1      0: count leading zeros, 1: count leading ones
//   out_valid  out  1      output beat valid
//   out_ready  in   1      downstream accepts output this cycle
//   out_data   out  WIDTH  normalised mantissa
//   out_exp    out  EXP_W  adjusted exponent
//   out_lzc    out  CNT_W  raw leading zero/one count (0..WIDTH)
//   out_zero   out  1      no terminating bit found (whole word matched)
//   out_uflow  out  1      count exceeded exponent, shift was clamped
// ---------------------------------------------------------------------------
module lzc_normalizer_pipe #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_lzc,
  output logic             out_zero,
  output logic             out_uflow
);

  // Common width used when comparing the count against the exponent.
  localparam int CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  // ---------------- flow control ----------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1: leading-pattern count ----------------
  // Leading ones are counted as the leading zeros of the inverted word.
  logic [WIDTH-1:0] scan_vec;
  logic [WIDTH-1:0] lead_run;
  logic [CNT_W-1:0] lzc_cnt;

  assign scan_vec = in_mode ? ~in_data : in_data;

  // lead_run[gi] is set when the top gi+1 bits are all zero.
  // The number of set bits is therefore the leading-zero count.
  // Each bit is an independent reduction, so there is no ripple chain.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lead_run
      assign lead_run[gi] = ~|scan_vec[WIDTH-1:WIDTH-1-gi];
    end
  endgenerate

  always_comb begin
    lzc_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lzc_cnt = lzc_cnt + CNT_W'(lead_run[i]);
    end
  end

  logic [WIDTH-1:0] s1_data_reg;
  logic [EXP_W-1:0] s1_exp_reg;
  logic [CNT_W-1:0] s1_cnt_reg;
  logic             s1_all_match_reg;

  // ---------------- stage 2: shift and exponent adjust ----------------
  logic             over_next;
  logic [CNT_W-1:0] shift_amt;
  logic [WIDTH-1:0] data_next;
  logic [EXP_W-1:0] exp_next;
  logic             uflow_next;

  always_comb begin
    over_next = CMP_W'(s1_cnt_reg) > CMP_W'(s1_exp_reg);
    // When clamped, the exponent is smaller than the count (<= WIDTH).
    // The exponent therefore fits in CNT_W bits.
    shift_amt = over_next ? CNT_W'(s1_exp_reg) : s1_cnt_reg;
    // A shift of WIDTH or more yields all zeros.
    data_next = s1_data_reg << shift_amt;
    // shift_amt <= exponent, so this subtraction never wraps.
    // An all-match word is forced to exponent 0.
    exp_next = s1_all_match_reg ? '0 : (s1_exp_reg - EXP_W'(shift_amt));
    uflow_next = over_next && !s1_all_match_reg;
  end

  logic [WIDTH-1:0] s2_data_reg;
  logic [EXP_W-1:0] s2_exp_reg;
  logic [CNT_W-1:0] s2_lzc_reg;
  logic             s2_zero_reg;
  logic             s2_uflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg     <= 1'b0;
      s1_data_reg      <= '0;
      s1_exp_reg       <= '0;
      s1_cnt_reg       <= '0;
      s1_all_match_reg <= 1'b0;
      s2_valid_reg     <= 1'b0;
      s2_data_reg      <= '0;
      s2_exp_reg       <= '0;
      s2_lzc_reg       <= '0;
      s2_zero_reg      <= 1'b0;
      s2_uflow_reg     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        // The payload is captured only for an accepted beat.
        // This keeps the registers free of stray input values.
        if (in_valid) begin
          s1_data_reg      <= in_data;
          s1_exp_reg       <= in_exp;
          s1_cnt_reg       <= lzc_cnt;
          s1_all_match_reg <= (lzc_cnt == CNT_W'(WIDTH));
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        // The output payload keeps its last value when no beat moves.
        if (s1_valid_reg) begin
          s2_data_reg  <= data_next;
          s2_exp_reg   <= exp_next;
          s2_lzc_reg   <= s1_cnt_reg;
          s2_zero_reg  <= s1_all_match_reg;
          s2_uflow_reg <= uflow_next;
        end
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign out_exp   = s2_exp_reg;
  assign out_lzc   = s2_lzc_reg;
  assign out_zero  = s2_zero_reg;
  assign out_uflow = s2_uflow_reg;

endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
// ---------------------------------------------------------------------------
// tb_lzc_normalizer_pipe
//
// Self-checking bench for lzc_normalizer_pipe with WIDTH=32 and EXP_W=8.
// It runs four phases in order:
//   - reset values;
//   - directed normalisation beats with a fixed two-cycle latency;
//   - random beats under random backpressure, checked in order against a
//     reference model, with in_ready and stall-hold checks;
//   - a reset while both stages are full.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_lzc_normalizer_pipe;
  localparam int W = 32;
  localparam int E = 8;
  localparam int C = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [E-1:0] in_exp;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [E-1:0] out_exp;
  logic [C-1:0] out_lzc;
  logic         out_zero;
  logic         out_uflow;

  always #5 clk = ~clk;

  lzc_normalizer_pipe #(.WIDTH(W), .EXP_W(E)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_exp(in_exp), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_exp(out_exp), .out_lzc(out_lzc),
    .out_zero(out_zero), .out_uflow(out_uflow)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [E-1:0] exp;
    logic [C-1:0] lzc;
    logic         zero;
    logic         uflow;
  } beat_t;

  int total = 0;
  int bad   = 0;
  beat_t q[$];

  // Reference model. It walks the bits to count the leading run.
  // It then applies the clamp rule using integer arithmetic.
  function automatic beat_t model(input logic [W-1:0] d, input logic [E-1:0] e,
                                  input logic m);
    beat_t r;
    logic [W-1:0] v;
    int c;
    int sh;
    v = m ? ~d : d;
    c = 0;
    while (c < W && v[W-1-c] == 1'b0) c++;
    sh = (c > int'(e)) ? int'(e) : c;
    r.data  = (sh >= W) ? '0 : (d << sh);
    r.lzc   = C'(c);
    r.zero  = (c == W);
    r.exp   = r.zero ? '0 : E'(int'(e) - sh);
    r.uflow = (c > int'(e)) && !r.zero;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t e);
    chk({tag, " data"},  64'(out_data),  64'(e.data));
    chk({tag, " exp"},   64'(out_exp),   64'(e.exp));
    chk({tag, " lzc"},   64'(out_lzc),   64'(e.lzc));
    chk({tag, " zero"},  64'(out_zero),  64'(e.zero));
    chk({tag, " uflow"}, 64'(out_uflow), 64'(e.uflow));
  endtask

  // Waits for the next rising edge, then 1 time unit more.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Sends one beat into an empty pipe with out_ready=1.
  // Checks that the result appears exactly two edges after acceptance.
  task automatic directed(input string tag, input logic [W-1:0] d, input logic [E-1:0] e,
                          input logic m, input beat_t req);
    in_valid = 1'b1; in_data = d; in_exp = e; in_mode = m; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk({tag, " lat1 valid"}, 64'(out_valid), 64'd0);
    next_cycle();
    #1;
    chk({tag, " lat2 valid"}, 64'(out_valid), 64'd1);
    chk_beat(tag, req);
    $display("beat %s: data=%08h exp=%0d mode=%0d -> data=%08h exp=%0d lzc=%0d z=%0d u=%0d",
             tag, d, e, m, out_data, out_exp, out_lzc, out_zero, out_uflow);
    next_cycle();
  endtask

  initial begin
    beat_t b;
    beat_t prev;
    logic  prev_stall;
    logic  pending;
    int    sent;
    int    cycles;

    in_valid = 1'b0; in_data = '0; in_exp = '0; in_mode = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data",  64'(out_data),  64'd0);
    chk("reset out_lzc",   64'(out_lzc),   64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);

    // Directed beats. Expected values are worked out by hand.
    b = '{data: 32'h8000_0000, exp: 8'd84, lzc: 6'd16, zero: 1'b0, uflow: 1'b0};
    directed("lz16", 32'h0000_8000, 8'd100, 1'b0, b);
    b = '{data: 32'h0000_0000, exp: 8'd0, lzc: 6'd32, zero: 1'b1, uflow: 1'b0};
    directed("allzero", 32'h0000_0000, 8'd50, 1'b0, b);
    b = '{data: 32'h0000_0400, exp: 8'd0, lzc: 6'd31, zero: 1'b0, uflow: 1'b1};
    directed("uflow", 32'h0000_0001, 8'd10, 1'b0, b);
    b = '{data: 32'h0F00_0000, exp: 8'd84, lzc: 6'd16, zero: 1'b0, uflow: 1'b0};
    directed("lo16", 32'hFFFF_0F00, 8'd100, 1'b1, b);
    b = '{data: 32'h8000_0000, exp: 8'd0, lzc: 6'd12, zero: 1'b0, uflow: 1'b0};
    directed("exact", 32'h0008_0000, 8'd12, 1'b0, b);
    b = '{data: 32'hFFFF_F000, exp: 8'd0, lzc: 6'd32, zero: 1'b1, uflow: 1'b0};
    directed("allone", 32'hFFFF_FFFF, 8'd12, 1'b1, b);

    // Random beats under random backpressure.
    sent = 0; cycles = 0; pending = 1'b0; prev_stall = 1'b0;
    prev = '{data: '0, exp: '0, lzc: '0, zero: 1'b0, uflow: 1'b0};
    while ((sent < 20 || q.size() > 0) && cycles < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!pending) begin
        if (sent < 20 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = $urandom() >> $urandom_range(0, 32);
          in_exp   = E'($urandom_range(0, 255) >> $urandom_range(0, 4));
          in_mode  = 1'($urandom_range(0, 1));
          if (in_mode) in_data = ~in_data;
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (prev_stall) begin
        chk("stall valid", 64'(out_valid), 64'd1);
        chk_beat("stall hold", prev);
      end
      chk("in_ready", 64'(in_ready), (q.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
      chk("spurious valid", 64'(out_valid && q.size() == 0), 64'd0);
      if (out_valid && out_ready && q.size() > 0) begin
        b = q.pop_front();
        chk_beat("rand", b);
        $display("rand out: data=%08h exp=%0d lzc=%0d z=%0d u=%0d",
                 out_data, out_exp, out_lzc, out_zero, out_uflow);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_exp, in_mode));
        sent++;
        pending = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev = '{data: out_data, exp: out_exp, lzc: out_lzc, zero: out_zero, uflow: out_uflow};
      next_cycle();
      cycles++;
    end
    chk("random drained", 64'(q.size()), 64'd0);
    in_valid = 1'b0;

    // Fill both stages, then apply reset in the middle of the cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00F0; in_exp = 8'd40; in_mode = 1'b0;
    next_cycle();
    in_data = 32'h0001_0000;
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("full in_ready", 64'(in_ready), 64'd0);
    chk("full out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst async out_valid", 64'(out_valid), 64'd0);
    chk("rst async in_ready", 64'(in_ready), 64'd1);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk("post-rst no out", 64'(out_valid), 64'd0);
    end
    $display("reset flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
